// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared ALU operation codes (also used by the decoder and the main ALU) and
// small helpers that classify the M-extension codes for the multiply/divide
// unit. No ports; imported by the muldiv unit files.
package muldiv_unit_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    // Shared ALU operation codes
    localparam logic [5:0] ALU_ADD    = 6'h00;
    localparam logic [5:0] ALU_SUB    = 6'h01;
    localparam logic [5:0] ALU_AND    = 6'h02;
    localparam logic [5:0] ALU_OR     = 6'h03;
    localparam logic [5:0] ALU_XOR    = 6'h04;
    localparam logic [5:0] ALU_MUL    = 6'h10;
    localparam logic [5:0] ALU_MULH   = 6'h11;
    localparam logic [5:0] ALU_MULHSU = 6'h12;
    localparam logic [5:0] ALU_MULHU  = 6'h13;
    localparam logic [5:0] ALU_DIV    = 6'h14;
    localparam logic [5:0] ALU_DIVU   = 6'h15;
    localparam logic [5:0] ALU_REM    = 6'h16;
    localparam logic [5:0] ALU_REMU   = 6'h17;

    function automatic logic is_muldiv(input logic [5:0] code);
        case (code)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [5:0] code);
        case (code)
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic op1_signed(input logic [5:0] code);
        case (code)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic op2_signed(input logic [5:0] code);
        case (code)
            ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix
// Conditional two's-complement negation. Used both to take operand
// magnitudes (neg = operand is signed and negative) and to restore the sign
// of the unsigned results.
// Ports:
//   mag   in  WIDTH  value to pass through or negate
//   neg   in  1      negate when high
//   value out WIDTH  mag or -mag
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mag,
    input  logic             neg,
    output logic [WIDTH-1:0] value
);

    assign value = neg ? -mag : mag;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit. One radix-2 step per cycle on operand
// magnitudes (shift-add multiply, restoring divide), then a sign fix. Fixed
// latency: done pulses 33 cycles after the start is accepted.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request a new operation (only accepted in IDLE)
//   alucode  in   6-bit ALU operation code (MUL..REMU)
//   op1,op2  in   32-bit rs1 / rs2 values
//   abort    in   cancel the in-flight operation
//   busy     out  high while an operation is in RUN or FINISH
//   done     out  one-cycle pulse, result valid
//   result   out  32-bit rd value, held between done pulses
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  alucode,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_next;
    logic   accept;

    logic [5:0]        code_q;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic [CNT_W-1:0]  cnt;
    // Shared accumulator: multiply keeps the 64-bit partial product;
    // divide keeps the partial remainder in [63:32] and quotient in [31:0].
    logic [2*DATA_W-1:0] acc;

    logic              neg1, neg2, op2_zero, neg_prod, neg_quot;
    logic [DATA_W-1:0] mag1, mag2;

    logic [CNT_W-1:0]    bit_idx;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift, div_trial;
    logic                div_ge;
    logic [2*DATA_W-1:0] acc_next;

    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   quot_s, rem_s;
    logic [DATA_W-1:0]   result_next;

    // Operand sign handling
    assign neg1     = op1_signed(code_q) & op1_q[DATA_W-1];
    assign neg2     = op2_signed(code_q) & op2_q[DATA_W-1];
    assign op2_zero = (op2_q == '0);
    assign neg_prod = neg1 ^ neg2;
    // Divide by zero must leave the all-ones quotient untouched.
    assign neg_quot = (neg1 ^ neg2) & ~op2_zero;

    muldiv_signfix #(.WIDTH(DATA_W)) u_fix_op1 (.mag(op1_q), .neg(neg1), .value(mag1));
    muldiv_signfix #(.WIDTH(DATA_W)) u_fix_op2 (.mag(op2_q), .neg(neg2), .value(mag2));

    // Iteration step. The counter runs 31..0: multiply consumes multiplier
    // bits LSB first (index ~cnt), divide consumes dividend bits MSB first.
    assign bit_idx   = ~cnt;
    assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (mag2[bit_idx] ? {1'b0, mag1} : '0);
    assign div_shift = {acc[2*DATA_W-1:DATA_W], mag1[cnt]};
    assign div_trial = div_shift - {1'b0, mag2};
    // Partial remainder stays below the divisor, so bit 32 is a clean borrow.
    assign div_ge    = ~div_trial[DATA_W];

    always_comb begin
        acc_next = acc;
        if (is_div(code_q)) begin
            if (div_ge) acc_next = {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            else        acc_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[DATA_W-1:1]};
        end
    end

    // Result sign fix
    muldiv_signfix #(.WIDTH(2*DATA_W)) u_fix_prod (.mag(acc), .neg(neg_prod), .value(prod_s));
    muldiv_signfix #(.WIDTH(DATA_W)) u_fix_quot (.mag(acc[DATA_W-1:0]), .neg(neg_quot), .value(quot_s));
    muldiv_signfix #(.WIDTH(DATA_W)) u_fix_rem (.mag(acc[2*DATA_W-1:DATA_W]), .neg(neg1), .value(rem_s));

    always_comb begin
        result_next = result;
        case (code_q)
            ALU_MUL:                          result_next = prod_s[DATA_W-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  result_next = prod_s[2*DATA_W-1:DATA_W];
            ALU_DIV, ALU_DIVU:                result_next = quot_s;
            ALU_REM, ALU_REMU:                result_next = rem_s;
            default:                          result_next = result;
        endcase
    end

    // Control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort && is_muldiv(alucode)) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort)           state_next = IDLE;
                else if (cnt == '0)  state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                code_q <= alucode;
                op1_q  <= op1;
                op2_q  <= op2;
                cnt    <= 5'd31;
                acc    <= '0;
            end else if (state == RUN && !abort) begin
                cnt <= cnt - 5'd1;
                acc <= acc_next;
            end else if (state == FINISH && !abort) begin
                result <= result_next;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed and randomized bench for muldiv_unit with a reference model built
// from 64-bit integer arithmetic.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  alucode;
    logic [31:0] op1, op2;
    logic        abort;
    logic        busy, done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result = '0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alucode(alucode),
        .op1(op1), .op2(op2), .abort(abort),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [5:0] code, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (code)
            ALU_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            ALU_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation at the current negedge and follows it for 40 cycles.
    task automatic run_op(input string tag, input logic [5:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit poke);
        int          done_at, done_cnt;
        bit          busy_ok;
        logic [31:0] res_at_done;
        start = 1'b1; alucode = code; op1 = a; op2 = b;
        @(negedge clk);
        start = 1'b0; alucode = 6'($urandom); op1 = $urandom; op2 = $urandom;
        busy_ok = (busy === 1'b1);
        done_at = -1; done_cnt = 0; res_at_done = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (poke && k == 5) begin
                start = 1'b1; alucode = ALU_DIVU; op1 = $urandom; op2 = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; res_at_done = result; end
            end
            if (k < 33 && busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, "_result"}, res_at_done, exp);
        check({tag, "_latency"}, done_at, 33);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_hold"}, result, exp);
        last_result = exp;
    endtask

    logic [5:0] codes [8];

    initial begin
        codes = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                  ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        rst_n = 1'b0; start = 1'b0; alucode = '0; op1 = '0; op2 = '0; abort = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_op("mul_7x-3", ALU_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mulhu_m1", ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("mulh_m1", ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_op("mulhsu_m1", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("div_m7_2", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
        run_op("rem_m7_2", ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
        run_op("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_op("rem_ovf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_op("divu_by0", ALU_DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b0);
        run_op("remu_by0", ALU_REMU, 32'd100, 32'd0, 32'd100, 1'b0);
        run_op("div_by0_neg", ALU_DIV, 32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, 1'b0);
        run_op("rem_by0_neg", ALU_REM, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 1'b0);

        // start while busy is ignored
        run_op("start_busy", ALU_MULHU, 32'h12345678, 32'h9ABCDEF0,
               ref_model(ALU_MULHU, 32'h12345678, 32'h9ABCDEF0), 1'b1);

        // Abort on the 10th RUN cycle, then restart immediately
        start = 1'b1; alucode = ALU_MUL; op1 = 32'd1234; op2 = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_run_busy", busy, 0);
        check("abort_run_done", done, 0);
        check("abort_run_result", result, last_result);
        run_op("after_abort", ALU_DIVU, 32'd1000, 32'd7, 32'd142, 1'b0);

        // Abort in FINISH beats the done pulse
        start = 1'b1; alucode = ALU_MUL; op1 = 32'd3; op2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        check("finish_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_fin_done", done, 0);
        check("abort_fin_busy", busy, 0);
        check("abort_fin_result", result, last_result);

        // start and abort together in IDLE: not accepted
        start = 1'b1; abort = 1'b1; alucode = ALU_MUL; op1 = 32'd5; op2 = 32'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        begin
            bit quiet;
            quiet = (busy === 1'b0);
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
            end
            check("start_abort_idle", quiet, 1);
        end
        check("start_abort_result", result, last_result);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  c;
            logic [31:0] a, b;
            c = codes[$urandom_range(0, 7)];
            a = rand_operand();
            b = rand_operand();
            run_op($sformatf("rand%0d_op%0h", i, c), c, a, b, ref_model(c, a, b), 1'b0);
        end

        // Reset asserted mid-RUN
        start = 1'b1; alucode = ALU_DIV; op1 = 32'd999; op2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        last_result = '0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit no_done;
            no_done = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
            end
            check("midrst_no_done", no_done, 1);
        end

        // Non-muldiv code is ignored
        start = 1'b1; alucode = ALU_ADD; op1 = 32'd1; op2 = 32'd2;
        @(negedge clk);
        start = 1'b0;
        begin
            bit idle_ok;
            idle_ok = (busy === 1'b0);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (busy !== 1'b0) idle_ok = 1'b0;
            end
            check("add_ignored", idle_ok, 1);
        end

        // Unit still works after that
        run_op("final_rem", ALU_REM, 32'd17, 32'hFFFFFFFB, 32'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; driven high by execute when the decoder flags is_multiclock.
REQ-004 SHALL have port alucode, input, 6 bits: operation select from the shared ALU codes ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
REQ-005 SHALL have ports op1 and op2, input, 32 bits each: rs1 and rs2 operand values.
REQ-006 SHALL have port abort, input, 1 bit: cancel the in-flight operation (pipeline flush).
REQ-007 SHALL have port busy, output, 1 bit: operation in progress; the pipeline stalls while it is high.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-009 SHALL have port result, output, 32 bits: rd write value.

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN and FINISH.
REQ-011 IDLE->RUN SHALL occur when start=1 and alucode is one of the eight codes in REQ-004.
- On that transition: latch alucode, op1 and op2; load iteration counter with 31.
- start with any other alucode: ignored, remain in IDLE.
REQ-012 RUN SHALL perform one radix-2 step per cycle on operand magnitudes.
- Multiply: shift-add into a 64-bit accumulator.
- Divide: restoring; 32-bit quotient and remainder.
- RUN->FINISH when the counter reaches 0.
REQ-013 Latency SHALL be fixed: start accepted at edge N gives done=1 during cycle N+33 (32 RUN cycles plus 1 FINISH cycle), for every op and operand value.
REQ-014 FINISH SHALL apply the sign fix, register result, pulse done for exactly one cycle, then return to IDLE.
REQ-015 Signedness SHALL be:
- MUL, MULH, DIV, REM: both operands signed.
- MULHSU: op1 signed, op2 unsigned.
- MULHU, DIVU, REMU: both unsigned.
REQ-016 Result selection SHALL be: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-017 Division signs SHALL follow: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-018 Divide by zero SHALL give: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU result equal to op1.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give: DIV 0x80000000; REM 0.
REQ-020 busy SHALL be 1 in RUN and FINISH, and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 abort=1 in RUN or FINISH SHALL return the FSM to IDLE at the next edge.
- done is suppressed in that cycle.
- result keeps its previous value.
- abort has priority over the FINISH done pulse.
- abort in IDLE has no effect.
REQ-023 start and abort both high in IDLE: abort SHALL win; the operation is not accepted.
REQ-024 result SHALL hold its last value between done pulses.

Reset
REQ-025 While rst_n=0 the block SHALL hold: state=IDLE, busy=0, done=0, result=0, and the counter, accumulators and latched operands all zero.
REQ-026 rst_n asserted mid-RUN SHALL immediately discard the operation; no done follows the release of reset.

Structure
REQ-027 The eight M-extension ALU codes SHALL come from the shared define header already used by the decoder and ALU; FSM state encodings SHALL be local constants.
REQ-028 Sign-fix logic (magnitude in, negate-on-flag out) SHALL be one sub-module, muldiv_signfix, instantiated for operands and for results.

Verification
REQ-029 The bench SHALL cover MUL, op1=7, op2=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after start, busy high throughout.
REQ-030 The bench SHALL cover op1=op2=0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULH 0x00000000; MULHSU 0xFFFFFFFF.
REQ-031 The bench SHALL cover DIV op1=0xFFFFFFF9 (-7), op2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-032 The bench SHALL cover DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100, both at standard latency.
REQ-033 The bench SHALL cover abort on the 10th RUN cycle -> busy=0 next cycle, no done, result unchanged; a new start the following cycle completes normally.
REQ-034 The bench SHALL cover rst_n pulsed low mid-RUN -> all outputs 0 immediately, no done afterwards; start with alucode ALU_ADD -> busy stays 0.
